// File: rtl/counter_chk_pkg.sv
// Shared types and defaults for the counter stream checker.
package counter_chk_pkg;

  // Checker FSM: search for a seed, confirm a run, then track the stream.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_SYNC_CNT = 4;
  localparam int unsigned DEF_LOSS_CNT = 3;
  localparam int unsigned DEF_CNT_W    = 16;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/counter_stream_checker_sat_counter.sv
// Saturating statistics counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear first, otherwise increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side checker for an incrementing counter bus: acquires sync,
// tracks the stream with a flywheel expected value, flags and counts misses.
// Optional macro COUNTER_CHK_ERR_CAPTURE_EN adds first-error capture outputs.
module counter_stream_checker
  import counter_chk_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned SYNC_CNT = DEF_SYNC_CNT,
  parameter int unsigned LOSS_CNT = DEF_LOSS_CNT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  err_count
`ifdef COUNTER_CHK_ERR_CAPTURE_EN
  ,
  output logic              cap_vld,
  output logic [DATA_W-1:0] cap_exp,
  output logic [DATA_W-1:0] cap_got
`endif
);

  localparam int unsigned RUN_W = cnt_width(SYNC_CNT);
  localparam int unsigned BAD_W = cnt_width(LOSS_CNT);
  // Comparing against count-1 avoids needing an extra bit for run+1.
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(SYNC_CNT - 1);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(LOSS_CNT - 1);

  chk_state_e        state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [BAD_W-1:0]  bad_run_q, bad_run_d;
  logic              err_pulse_q, err_pulse_d;
  logic              locked_q, locked_d;
  logic              seq_match;
  logic              good_inc;
  logic              err_inc;

  assign seq_match = (in_data == exp_q);

  // FSM and sequence tracking; nothing moves on cycles without in_valid.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    bad_run_d   = bad_run_q;
    err_pulse_d = 1'b0;
    good_inc    = 1'b0;
    err_inc     = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          exp_d     = in_data + DATA_W'(1);
          run_d     = RUN_W'(1);
          bad_run_d = '0;
          state_d   = ST_SYNC;
        end
        ST_SYNC: begin
          // Whether or not it matched, the next expected value follows this sample.
          exp_d = in_data + DATA_W'(1);
          if (seq_match) begin
            run_d = run_q + RUN_W'(1);
            if (run_q == RUN_LAST) begin
              state_d   = ST_LOCKED;
              bad_run_d = '0;
            end
          end else begin
            run_d = RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          // Flywheel: expected value advances regardless of what arrived.
          exp_d = exp_q + DATA_W'(1);
          if (seq_match) begin
            good_inc  = 1'b1;
            bad_run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (bad_run_q == BAD_LAST) begin
              state_d   = ST_HUNT;
              bad_run_d = '0;
            end else begin
              bad_run_d = bad_run_q + BAD_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Tracking state and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      exp_q       <= '0;
      run_q       <= '0;
      bad_run_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      bad_run_q   <= bad_run_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

  sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (good_inc),
    .clr   (clr_cnt),
    .count (good_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clr_cnt),
    .count (err_count)
  );

`ifdef COUNTER_CHK_ERR_CAPTURE_EN
  logic              cap_vld_q, cap_vld_d;
  logic [DATA_W-1:0] cap_exp_q, cap_exp_d;
  logic [DATA_W-1:0] cap_got_q, cap_got_d;

  // Keep only the first locked mismatch since the last clear.
  always_comb begin
    cap_vld_d = cap_vld_q;
    cap_exp_d = cap_exp_q;
    cap_got_d = cap_got_q;
    if (clr_cnt) begin
      cap_vld_d = 1'b0;
      cap_exp_d = '0;
      cap_got_d = '0;
    end else if (err_inc && !cap_vld_q) begin
      cap_vld_d = 1'b1;
      cap_exp_d = exp_q;
      cap_got_d = in_data;
    end
  end

  // Capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_vld_q <= 1'b0;
      cap_exp_q <= '0;
      cap_got_q <= '0;
    end else begin
      cap_vld_q <= cap_vld_d;
      cap_exp_q <= cap_exp_d;
      cap_got_q <= cap_got_d;
    end
  end

  assign cap_vld = cap_vld_q;
  assign cap_exp = cap_exp_q;
  assign cap_got = cap_got_q;
`endif

endmodule

// File: tb/tb_counter_stream_checker.sv
// Randomized bench for counter_stream_checker with a behavioural model,
// a per-cycle compare process and directed literal checkpoints.
module tb_counter_stream_checker;

  localparam int DATA_W   = 8;
  localparam int SYNC_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int CNT_W    = 6;   // small so saturation is reachable
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              clr_cnt;
  logic              locked;
  logic              err_pulse;
  logic [CNT_W-1:0]  good_count;
  logic [CNT_W-1:0]  err_count;
`ifdef COUNTER_CHK_ERR_CAPTURE_EN
  logic              cap_vld;
  logic [DATA_W-1:0] cap_exp;
  logic [DATA_W-1:0] cap_got;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  counter_stream_checker #(
    .DATA_W   (DATA_W),
    .SYNC_CNT (SYNC_CNT),
    .LOSS_CNT (LOSS_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clr_cnt    (clr_cnt),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .good_count (good_count),
    .err_count  (err_count)
`ifdef COUNTER_CHK_ERR_CAPTURE_EN
    ,
    .cap_vld    (cap_vld),
    .cap_exp    (cap_exp),
    .cap_got    (cap_got)
`endif
  );

  // ---------------- behavioural model ----------------
  // mode: 0 = searching, 1 = confirming run, 2 = locked
  int m_mode, m_exp, m_run, m_bad, m_good, m_err;
  bit m_pulse;
  bit m_cap_vld;
  int m_cap_exp, m_cap_got;

  always @(posedge clk) begin
    bit hit_good;
    bit hit_err;
    hit_good = 1'b0;
    hit_err  = 1'b0;
    m_pulse  = 1'b0;
    if (reset) begin
      m_mode = 0; m_exp = 0; m_run = 0; m_bad = 0;
      m_good = 0; m_err = 0;
      m_cap_vld = 1'b0; m_cap_exp = 0; m_cap_got = 0;
    end else begin
      if (in_valid) begin
        if (m_mode == 0) begin
          m_exp  = (int'(in_data) + 1) % 256;
          m_run  = 1;
          m_mode = 1;
        end else if (m_mode == 1) begin
          if (int'(in_data) == m_exp) begin
            m_run = m_run + 1;
            if (m_run == SYNC_CNT) begin
              m_mode = 2;
              m_bad  = 0;
            end
          end else begin
            m_run = 1;
          end
          m_exp = (int'(in_data) + 1) % 256;
        end else begin
          if (int'(in_data) == m_exp) begin
            hit_good = 1'b1;
            m_bad    = 0;
          end else begin
            hit_err = 1'b1;
            m_pulse = 1'b1;
            if (!m_cap_vld && !clr_cnt) begin
              m_cap_vld = 1'b1;
              m_cap_exp = m_exp;
              m_cap_got = int'(in_data);
            end
            m_bad = m_bad + 1;
            if (m_bad == LOSS_CNT) begin
              m_mode = 0;
              m_bad  = 0;
            end
          end
          m_exp = (m_exp + 1) % 256;
        end
      end
      if (clr_cnt) begin
        m_good = 0; m_err = 0;
        m_cap_vld = 1'b0; m_cap_exp = 0; m_cap_got = 0;
      end else begin
        if (hit_good && m_good < CNT_MAX) m_good = m_good + 1;
        if (hit_err && m_err < CNT_MAX) m_err = m_err + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("locked", 32'(locked), 32'(m_mode == 2));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
      chk("good_count", 32'(good_count), 32'(m_good));
      chk("err_count", 32'(err_count), 32'(m_err));
`ifdef COUNTER_CHK_ERR_CAPTURE_EN
      chk("cap_vld", 32'(cap_vld), 32'(m_cap_vld));
      chk("cap_exp", 32'(cap_exp), 32'(m_cap_exp));
      chk("cap_got", 32'(cap_got), 32'(m_cap_got));
`endif
    end
  end

  // One accepted clock edge with the given inputs; returns at the next negedge.
  task automatic step(input bit v, input int d, input bit c);
    in_valid = v;
    in_data  = 8'(d);
    clr_cnt  = c;
    @(posedge clk);
    @(negedge clk);
    $display("[TB] v=%0b d=%02h clr=%0b -> locked=%0b err_pulse=%0b good=%0d err=%0d",
             v, 8'(d), c, locked, err_pulse, good_count, err_count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    int src;
    int r;
    bit v;
    int d;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clr_cnt  = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset state
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_good", 32'(good_count), 0);
    chk("rst_err", 32'(err_count), 0);

    // Acquire lock on 0x10..0x13
    step(1, 8'h10, 0); step(1, 8'h11, 0); step(1, 8'h12, 0);
    chk("sync_not_yet", 32'(locked), 0);
    step(1, 8'h13, 0);
    chk("sync_locked", 32'(locked), 1);
    chk("sync_good0", 32'(good_count), 0);
    chk("sync_err0", 32'(err_count), 0);

    // Wrap 0xFE..0x01 accepted while locked
    do_reset();
    step(1, 8'hFA, 0); step(1, 8'hFB, 0); step(1, 8'hFC, 0); step(1, 8'hFD, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, (8'hFE + i) % 256, 0);
      chk("wrap_no_pulse", 32'(err_pulse), 0);
    end
    chk("wrap_good4", 32'(good_count), 4);
    chk("wrap_model_good4", 32'(m_good), 4);

    // Single error with flywheel: expect 0x40, send 0x55 then 0x41
    do_reset();
    step(1, 8'h3C, 0); step(1, 8'h3D, 0); step(1, 8'h3E, 0); step(1, 8'h3F, 0);
    step(1, 8'h55, 0);
    chk("fly_pulse", 32'(err_pulse), 1);
    chk("fly_err1", 32'(err_count), 1);
    step(1, 8'h41, 0);
    chk("fly_pulse_low", 32'(err_pulse), 0);
    chk("fly_locked", 32'(locked), 1);
    chk("fly_good1", 32'(good_count), 1);

    // Three consecutive misses drop lock; four new samples regain it
    step(1, 8'h99, 0); chk("loss_p1", 32'(err_pulse), 1);
    step(1, 8'h99, 0); chk("loss_p2", 32'(err_pulse), 1);
    chk("loss_still_locked", 32'(locked), 1);
    step(1, 8'h99, 0); chk("loss_p3", 32'(err_pulse), 1);
    chk("loss_unlocked", 32'(locked), 0);
    chk("loss_err4", 32'(err_count), 4);
    step(1, 8'h20, 0); step(1, 8'h21, 0); step(1, 8'h22, 0);
    chk("resync_not_yet", 32'(locked), 0);
    step(1, 8'h23, 0);
    chk("resync_locked", 32'(locked), 1);

    // Alternating valid/invalid with garbage on invalid cycles
    for (int i = 0; i < 8; i++) begin
      step(1, 8'h24 + i, 0);
      step(0, 8'hA5 ^ i, 0);
      chk("gap_no_pulse", 32'(err_pulse), 0);
    end
    chk("gap_good9", 32'(good_count), 9);
    chk("gap_err4", 32'(err_count), 4);

    // Clear coincident with a mismatch (expected 0x2C)
    step(1, 8'h77, 1);
    chk("clr_err0", 32'(err_count), 0);
    chk("clr_pulse", 32'(err_pulse), 1);
    chk("clr_good0", 32'(good_count), 0);
`ifdef COUNTER_CHK_ERR_CAPTURE_EN
    chk("clr_cap_vld0", 32'(cap_vld), 0);
`endif
    step(1, 8'h2D, 0);
    step(1, 8'h00, 0);
    chk("recap_err1", 32'(err_count), 1);
`ifdef COUNTER_CHK_ERR_CAPTURE_EN
    chk("recap_vld", 32'(cap_vld), 1);
    chk("recap_exp", 32'(cap_exp), 32'h2E);
    chk("recap_got", 32'(cap_got), 32'h00);
`endif

    // Saturation of good_count
    for (int i = 0; i < 70; i++) step(1, (8'h2F + i) % 256, 0);
    chk("sat_good", 32'(good_count), CNT_MAX);
    chk("sat_model_good", 32'(m_good), CNT_MAX);

    // Randomized traffic: mostly in-sequence, with injected errors, jumps, clears, resets
    src = int'($urandom_range(0, 255));
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      v = ($urandom_range(0, 3) != 0);
      if (r < 4) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      if (r >= 990) src = int'($urandom_range(0, 255));
      if (r >= 900 && r < 980) d = int'($urandom_range(0, 255));
      else d = src;
      if (v) src = (src + 1) % 256;
      step(v, d, (r >= 980 && r < 990));
    end
    reset = 1'b0;
    step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
